// File: rtl/nasti_mem_tester.sv
// nasti_mem_tester: NASTI master traffic generator and checker.
// Writes NUM_BURSTS INCR bursts of a deterministic pattern starting at
// BASE_ADDR, then reads them back and compares every beat. Only one
// transaction is outstanding at any time.
// Each 32-bit lane of global beat i carries i ^ SEED. w_strb is always all ones.
// Optional build macro NASTI_MEM_TESTER_ERR_LOG_EN: when defined, the byte
// address of the first mismatching read beat of a run is captured on
// first_err_addr. When undefined, first_err_addr is tied to zero.

module nasti_mem_tester #(
    parameter int                    ID_WIDTH   = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    USER_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    BURST_LEN  = 4,
    parameter int                    NUM_BURSTS = 2,
    parameter logic [31:0]           SEED       = 32'hA5A5_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               err_count,
    output logic [ADDR_WIDTH-1:0]     first_err_addr,

    // write address channel
    output logic                      aw_valid,
    input  logic                      aw_ready,
    output logic [ID_WIDTH-1:0]       aw_id,
    output logic [ADDR_WIDTH-1:0]     aw_addr,
    output logic [7:0]                aw_len,
    output logic [2:0]                aw_size,
    output logic [1:0]                aw_burst,
    output logic                      aw_lock,
    output logic [3:0]                aw_cache,
    output logic [2:0]                aw_prot,
    output logic [3:0]                aw_qos,
    output logic [3:0]                aw_region,
    output logic [USER_WIDTH-1:0]     aw_user,

    // write data channel
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic [DATA_WIDTH/8-1:0]   w_strb,
    output logic                      w_last,
    output logic [USER_WIDTH-1:0]     w_user,

    // write response channel
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [ID_WIDTH-1:0]       b_id,
    input  logic [1:0]                b_resp,
    input  logic [USER_WIDTH-1:0]     b_user,

    // read address channel
    output logic                      ar_valid,
    input  logic                      ar_ready,
    output logic [ID_WIDTH-1:0]       ar_id,
    output logic [ADDR_WIDTH-1:0]     ar_addr,
    output logic [7:0]                ar_len,
    output logic [2:0]                ar_size,
    output logic [1:0]                ar_burst,
    output logic                      ar_lock,
    output logic [3:0]                ar_cache,
    output logic [2:0]                ar_prot,
    output logic [3:0]                ar_qos,
    output logic [3:0]                ar_region,
    output logic [USER_WIDTH-1:0]     ar_user,

    // read data channel
    input  logic                      r_valid,
    output logic                      r_ready,
    input  logic [ID_WIDTH-1:0]       r_id,
    input  logic [DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                r_resp,
    input  logic                      r_last,
    input  logic [USER_WIDTH-1:0]     r_user
);

    localparam int          BYTES       = DATA_WIDTH / 8;
    localparam int          LANES       = DATA_WIDTH / 32;
    localparam int          BURST_BYTES = BURST_LEN * BYTES;
    localparam logic [7:0]  LEN         = 8'(BURST_LEN - 1);
    localparam logic [8:0]  LAST_BEAT   = 9'(BURST_LEN - 1);
    localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);
    localparam logic [2:0]  SIZE        = 3'($clog2(BYTES));

    // Bursts must not cross a 4 KB boundary and lanes must tile the bus.
    if (BURST_LEN * DATA_WIDTH / 8 > 4096) begin : g_chk_4k
        $error("nasti_mem_tester: BURST_LEN*DATA_WIDTH/8 exceeds 4096 bytes");
    end
    if (DATA_WIDTH % 32 != 0) begin : g_chk_width
        $error("nasti_mem_tester: DATA_WIDTH must be a multiple of 32");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WA,
        S_WD,
        S_WB,
        S_RA,
        S_RD
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] burst_q, burst_d;
    logic [8:0]  beat_q, beat_d;
    logic        done_q, done_d;
    logic [15:0] err_count_q, err_count_d;

    logic                  start_ok;
    logic                  last_burst;
    logic                  last_beat;
    logic                  w_hs, b_hs, r_hs;
    logic                  wr_resp_err;
    logic                  rd_beat_err;
    logic                  rd_burst_end;
    logic [31:0]           beat_idx;
    logic [31:0]           lane_val;
    logic [DATA_WIDTH-1:0] pattern;
    logic [ADDR_WIDTH-1:0] burst_addr;

    // Response/read sideband fields carry no information for this tester.
    logic unused_inputs;
    assign unused_inputs = ^{b_id, b_user, r_id, r_user};

    // Shared decode: handshakes, pattern and burst address from counters.
    assign start_ok     = start && (state_q == S_IDLE);
    assign last_burst   = (burst_q == LAST_BURST);
    assign last_beat    = (beat_q == LAST_BEAT);
    assign w_hs         = w_valid && w_ready;
    assign b_hs         = b_valid && b_ready;
    assign r_hs         = r_valid && r_ready;
    assign beat_idx     = 32'(burst_q) * 32'(BURST_LEN) + 32'(beat_q);
    assign lane_val     = beat_idx ^ SEED;
    assign pattern      = {LANES{lane_val}};
    assign burst_addr   = BASE_ADDR + ADDR_WIDTH'(32'(burst_q) * 32'(BURST_BYTES));
    assign wr_resp_err  = b_hs && (b_resp != 2'b00);
    assign rd_beat_err  = r_hs && ((r_data != pattern) || (r_resp != 2'b00) ||
                                   (r_last != last_beat));
    assign rd_burst_end = r_hs && (r_last || last_beat);

    // State and counter registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            burst_q     <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic: walk write bursts, then read bursts, then back to idle.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start)                 state_d = S_WA;
            S_WA:   if (aw_ready)              state_d = S_WD;
            S_WD:   if (w_hs && last_beat)     state_d = S_WB;
            S_WB:   if (b_valid)               state_d = last_burst ? S_RA : S_WA;
            S_RA:   if (ar_ready)              state_d = S_RD;
            S_RD:   if (rd_burst_end)          state_d = last_burst ? S_IDLE : S_RA;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Counter, completion and error bookkeeping.
    always_comb begin
        burst_d     = burst_q;
        beat_d      = beat_q;
        done_d      = done_q;
        err_count_d = err_count_q;

        if (start_ok) begin
            burst_d     = '0;
            beat_d      = '0;
            done_d      = 1'b0;
            err_count_d = '0;
        end

        if (state_q == S_WD && w_hs) begin
            beat_d = last_beat ? 9'd0 : beat_q + 9'd1;
        end

        if (state_q == S_WB && b_hs) begin
            burst_d = last_burst ? 16'd0 : burst_q + 16'd1;
        end

        if (state_q == S_RD && r_hs) begin
            beat_d = rd_burst_end ? 9'd0 : beat_q + 9'd1;
            if (rd_burst_end) begin
                if (last_burst) begin
                    burst_d = '0;
                    done_d  = 1'b1;
                end else begin
                    burst_d = burst_q + 16'd1;
                end
            end
        end

        // At most one error source is active in any cycle (WB or RD).
        if ((wr_resp_err || rd_beat_err) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

`ifdef NASTI_MEM_TESTER_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
    logic                  err_logged_q, err_logged_d;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign beat_addr = burst_addr + ADDR_WIDTH'(32'(beat_q) * 32'(BYTES));

    // Capture register for the first failing read beat of a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_addr_q <= '0;
            err_logged_q     <= 1'b0;
        end else begin
            first_err_addr_q <= first_err_addr_d;
            err_logged_q     <= err_logged_d;
        end
    end

    // Latch the address once per run; a new run re-arms the capture.
    always_comb begin
        first_err_addr_d = first_err_addr_q;
        err_logged_d     = err_logged_q;
        if (start_ok) begin
            first_err_addr_d = '0;
            err_logged_d     = 1'b0;
        end else if (rd_beat_err && !err_logged_q) begin
            first_err_addr_d = beat_addr;
            err_logged_d     = 1'b1;
        end
    end

    assign first_err_addr = first_err_addr_q;
`else
    assign first_err_addr = '0;
`endif

    // Channel valids/readies decoded purely from the registered state.
    always_comb begin
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        b_ready  = 1'b0;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        case (state_q)
            S_WA: aw_valid = 1'b1;
            S_WD: begin
                w_valid = 1'b1;
                w_last  = last_beat;
            end
            S_WB: b_ready  = 1'b1;
            S_RA: ar_valid = 1'b1;
            S_RD: r_ready  = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err_count = err_count_q;

    assign aw_id     = '0;
    assign aw_addr   = burst_addr;
    assign aw_len    = LEN;
    assign aw_size   = SIZE;
    assign aw_burst  = 2'b01;
    assign aw_lock   = 1'b0;
    assign aw_cache  = '0;
    assign aw_prot   = '0;
    assign aw_qos    = '0;
    assign aw_region = '0;
    assign aw_user   = '0;

    assign w_data    = pattern;
    assign w_strb    = '1;
    assign w_user    = '0;

    assign ar_id     = '0;
    assign ar_addr   = burst_addr;
    assign ar_len    = LEN;
    assign ar_size   = SIZE;
    assign ar_burst  = 2'b01;
    assign ar_lock   = 1'b0;
    assign ar_cache  = '0;
    assign ar_prot   = '0;
    assign ar_qos    = '0;
    assign ar_region = '0;
    assign ar_user   = '0;

endmodule

// File: tb/tb_nasti_mem_tester.sv
// Directed testbench for nasti_mem_tester with default parameters.
// A small reactive slave (memory, optional backpressure, fault injection)
// answers the tester. A negedge monitor logs handshakes. All comparisons
// are made from the main initial block against hand-computed values.

module tb_nasti_mem_tester;

    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] err_count, first_err_addr;

    logic        aw_valid, aw_ready, aw_lock;
    logic [7:0]  aw_id, aw_len;
    logic [15:0] aw_addr;
    logic [2:0]  aw_size, aw_prot;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_cache, aw_qos, aw_region;
    logic [0:0]  aw_user;

    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [0:0]  w_user;

    logic        b_valid, b_ready;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;
    logic [0:0]  b_user;

    logic        ar_valid, ar_ready, ar_lock;
    logic [7:0]  ar_id, ar_len;
    logic [15:0] ar_addr;
    logic [2:0]  ar_size, ar_prot;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_cache, ar_qos, ar_region;
    logic [0:0]  ar_user;

    logic        r_valid, r_ready, r_last;
    logic [7:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [0:0]  r_user;

    always #5 clk = ~clk;

    nasti_mem_tester dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_lock(aw_lock),
        .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_region(aw_region),
        .aw_user(aw_user),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .w_last(w_last), .w_user(w_user),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_lock(ar_lock),
        .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
        .ar_user(ar_user),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last), .r_user(r_user)
    );

    // ---------------- slave model ----------------
    logic        bp_en = 1'b0;
    logic        corrupt_en = 1'b0;
    logic        bresp_err_en = 1'b0;

    logic [63:0] mem [0:63];
    logic [15:0] wr_addr, rd_addr;
    logic        b_pend, b_err_burst;
    logic [1:0]  b_resp_q;
    logic [8:0]  rd_rem;
    int unsigned aw_wait;
    logic        w_tog, r_gap;

    assign aw_ready = bp_en ? (aw_wait >= 5) : 1'b1;
    assign w_ready  = bp_en ? w_tog : 1'b1;
    assign ar_ready = 1'b1;
    assign b_valid  = b_pend;
    assign b_resp   = b_resp_q;
    assign b_id     = '0;
    assign b_user   = '0;
    assign r_valid  = (rd_rem != 9'd0) && !(bp_en && r_gap);
    assign r_data   = mem[rd_addr[8:3]] ^ ((corrupt_en && rd_addr == 16'h0028) ? 64'h1 : 64'h0);
    assign r_last   = (rd_rem == 9'd1);
    assign r_resp   = 2'b00;
    assign r_id     = '0;
    assign r_user   = '0;

    always @(posedge clk) begin
        if (rst) begin
            b_pend      <= 1'b0;
            b_err_burst <= 1'b0;
            b_resp_q    <= 2'b00;
            rd_rem      <= '0;
            aw_wait     <= 0;
            w_tog       <= 1'b0;
            r_gap       <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
        end else begin
            w_tog <= ~w_tog;
            r_gap <= ~r_gap;
            if (aw_valid && aw_ready) begin
                wr_addr     <= aw_addr;
                aw_wait     <= 0;
                b_err_burst <= bresp_err_en && (aw_addr == 16'h0000);
            end else if (aw_valid) begin
                aw_wait <= aw_wait + 1;
            end
            if (w_valid && w_ready) begin
                mem[wr_addr[8:3]] <= w_data;
                wr_addr <= wr_addr + 16'd8;
                if (w_last) begin
                    b_pend   <= 1'b1;
                    b_resp_q <= b_err_burst ? 2'b10 : 2'b00;
                end
            end
            if (b_valid && b_ready) b_pend <= 1'b0;
            if (ar_valid && ar_ready) begin
                rd_addr <= ar_addr;
                rd_rem  <= {1'b0, ar_len} + 9'd1;
            end
            if (r_valid && r_ready) begin
                rd_addr <= rd_addr + 16'd8;
                rd_rem  <= rd_rem - 9'd1;
            end
        end
    end

    // ---------------- handshake monitor ----------------
    int          aw_cnt, w_cnt, ar_cnt, aw_stall, aw_unstable, w_unstable;
    logic [15:0] aw_addr_log [0:3];
    logic [7:0]  aw_len_log  [0:3];
    logic [2:0]  aw_size_log [0:3];
    logic [1:0]  aw_burst_log[0:3];
    logic [15:0] ar_addr_log [0:3];
    logic [63:0] w_data_log  [0:15];
    logic        w_last_log  [0:15];
    logic        prev_aw_pend, prev_w_pend;
    logic [15:0] prev_aw_addr;
    logic [63:0] prev_w_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_aw_pend = 1'b0;
            prev_w_pend  = 1'b0;
        end else if (start && !busy) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_stall = 0; aw_unstable = 0; w_unstable = 0;
            prev_aw_pend = 1'b0;
            prev_w_pend  = 1'b0;
        end else begin
            if (aw_valid) begin
                if (prev_aw_pend && aw_addr != prev_aw_addr) aw_unstable++;
                if (aw_ready) begin
                    if (aw_cnt < 4) begin
                        aw_addr_log[aw_cnt]  = aw_addr;
                        aw_len_log[aw_cnt]   = aw_len;
                        aw_size_log[aw_cnt]  = aw_size;
                        aw_burst_log[aw_cnt] = aw_burst;
                    end
                    aw_cnt++;
                    prev_aw_pend = 1'b0;
                end else begin
                    aw_stall++;
                    prev_aw_pend = 1'b1;
                    prev_aw_addr = aw_addr;
                end
            end else begin
                if (prev_aw_pend) aw_unstable++;
                prev_aw_pend = 1'b0;
            end
            if (w_valid) begin
                if (prev_w_pend && w_data != prev_w_data) w_unstable++;
                if (w_ready) begin
                    if (w_cnt < 16) begin
                        w_data_log[w_cnt] = w_data;
                        w_last_log[w_cnt] = w_last;
                    end
                    w_cnt++;
                    prev_w_pend = 1'b0;
                end else begin
                    prev_w_pend = 1'b1;
                    prev_w_data = w_data;
                end
            end else begin
                if (prev_w_pend) w_unstable++;
                prev_w_pend = 1'b0;
            end
            if (ar_valid && ar_ready) begin
                if (ar_cnt < 4) ar_addr_log[ar_cnt] = ar_addr;
                ar_cnt++;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, {63'd0, done}, 64'd1);
    endtask

    task automatic check_end(input string tag, input logic [15:0] exp_err);
        @(negedge clk);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_err_count"}, {48'd0, err_count}, {48'd0, exp_err});
    endtask

    task automatic check_traffic(input string tag);
        logic [31:0] lane;
        logic [63:0] exp_data;
        check({tag, "_aw_cnt"}, 64'(aw_cnt), 64'd2);
        check({tag, "_ar_cnt"}, 64'(ar_cnt), 64'd2);
        check({tag, "_w_cnt"},  64'(w_cnt),  64'd8);
        check({tag, "_aw_unstable"}, 64'(aw_unstable), 64'd0);
        check({tag, "_w_unstable"},  64'(w_unstable),  64'd0);
        for (int b = 0; b < 2; b++) begin
            check($sformatf("%s_aw_addr%0d", tag, b), {48'd0, aw_addr_log[b]}, 64'(b * 32));
            check($sformatf("%s_aw_fields%0d", tag, b),
                  {51'd0, aw_len_log[b], aw_size_log[b], aw_burst_log[b]},
                  {51'd0, 8'd3, 3'd3, 2'd1});
            check($sformatf("%s_ar_addr%0d", tag, b), {48'd0, ar_addr_log[b]}, 64'(b * 32));
        end
        for (int i = 0; i < 8; i++) begin
            lane     = 32'(i) ^ SEED;
            exp_data = {lane, lane};
            check($sformatf("%s_w_data%0d", tag, i), w_data_log[i], exp_data);
            check($sformatf("%s_w_last%0d", tag, i), {63'd0, w_last_log[i]},
                  {63'd0, (i == 3 || i == 7)});
        end
        check({tag, "_fixed_zero"},
              {14'd0, aw_id, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user,
               ar_id, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user},
              64'd0);
        check({tag, "_ar_fields"}, {51'd0, ar_len, ar_size, ar_burst}, {51'd0, 8'd3, 3'd3, 2'd1});
        check({tag, "_w_strb_user"}, {55'd0, w_strb, w_user}, {55'd0, 8'hFF, 1'b0});
    endtask

    // Safety net in case a run never terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [15:0] exp_first;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        check("rst_first_err", {48'd0, first_err_addr}, 64'd0);
        check("rst_valids", {59'd0, aw_valid, w_valid, ar_valid, b_ready, r_ready}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Ideal slave
        pulse_start();
        @(negedge clk);
        check("ideal_busy_after_start", {63'd0, busy}, 64'd1);
        wait_done("ideal");
        check_end("ideal", 16'd0);
        check_traffic("ideal");
        repeat (5) @(negedge clk);
        check("ideal_done_held", {63'd0, done}, 64'd1);

        // Corrupted read beat 5
        corrupt_en = 1'b1;
        pulse_start();
        @(negedge clk);
        check("corrupt_done_cleared", {63'd0, done}, 64'd0);
        check("corrupt_busy", {63'd0, busy}, 64'd1);
        check("corrupt_err_cleared", {48'd0, err_count}, 64'd0);
        wait_done("corrupt");
        check_end("corrupt", 16'd1);
`ifdef NASTI_MEM_TESTER_ERR_LOG_EN
        exp_first = 16'h0028;
`else
        exp_first = 16'h0000;
`endif
        check("corrupt_first_err", {48'd0, first_err_addr}, {48'd0, exp_first});
        corrupt_en = 1'b0;

        // Error response on first write burst
        bresp_err_en = 1'b1;
        pulse_start();
        wait_done("bresp");
        check_end("bresp", 16'd1);
        check("bresp_first_err", {48'd0, first_err_addr}, 64'd0);
        bresp_err_en = 1'b0;

        // Backpressure on AW, W and R
        bp_en = 1'b1;
        pulse_start();
        wait_done("bp");
        check_end("bp", 16'd0);
        check_traffic("bp");
        check("bp_aw_stall", 64'(aw_stall), 64'd10);
        bp_en = 1'b0;

        // Reset in WD at beat 2 of the second burst (b_resp error already counted)
        bresp_err_en = 1'b1;
        pulse_start();
        n = 0;
        while (!(w_valid && w_cnt == 6) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reach_wd", {63'd0, (w_valid && w_cnt == 6)}, 64'd1);
        check("rstmid_err_before", {48'd0, err_count}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_valids", {59'd0, aw_valid, w_valid, ar_valid, b_ready, r_ready}, 64'd0);
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        check("rstmid_done", {63'd0, done}, 64'd0);
        check("rstmid_err_count", {48'd0, err_count}, 64'd0);
        bresp_err_en = 1'b0;

        // Clean run after reset, with extra start pulses while busy
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();
        @(negedge clk);
        check("restart_busy_mid", {63'd0, busy}, 64'd1);
        repeat (5) @(posedge clk);
        pulse_start();
        wait_done("restart");
        check_end("restart", 16'd0);
        check_traffic("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
